// File: rtl/candy_pkg.sv
// -----------------------------------------------------------------------------
// candy_pkg
// Shared definitions for the candy vending controller: FSM state encoding,
// coin values, key bit positions in key_in, change-coin strobe encodings and
// helpers that pick and value a change coin.
// -----------------------------------------------------------------------------
package candy_pkg;

   // Controller states.
   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_DISPENSE = 2'd1;
   localparam logic [1:0] ST_CHANGE   = 2'd2;

   // Coin values in credit units.
   localparam logic [7:0] COIN_10  = 8'd10;
   localparam logic [7:0] COIN_50  = 8'd50;
   localparam logic [7:0] COIN_100 = 8'd100;

   // Bit positions inside key_in. Bit 0 is not wired to anything.
   localparam int KEY_C100 = 5;
   localparam int KEY_C50  = 4;
   localparam int KEY_C10  = 3;
   localparam int KEY_BUY  = 2;
   localparam int KEY_RET  = 1;

   // One-hot change-coin strobe encodings.
   localparam logic [2:0] CHG_100 = 3'b100;
   localparam logic [2:0] CHG_50  = 3'b010;
   localparam logic [2:0] CHG_10  = 3'b001;

   // Largest coin not exceeding the amount still owed. Credit is always a
   // multiple of 10, so a nonzero amount always has a payable coin.
   function automatic logic [2:0] change_pick(input logic [7:0] amount);
      if (amount >= COIN_100)
         return CHG_100;
      else if (amount >= COIN_50)
         return CHG_50;
      else
         return CHG_10;
   endfunction

   // Credit value of a one-hot change strobe.
   function automatic logic [7:0] change_value(input logic [2:0] strobe);
      case (strobe)
         CHG_100: return COIN_100;
         CHG_50:  return COIN_50;
         CHG_10:  return COIN_10;
         default: return 8'd0;
      endcase
   endfunction

endpackage

// File: rtl/candy_vend_ctrl_key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Front end for one key: 2-flop synchronizer, stability counter and a
// one-cycle pulse on each debounced 0->1 transition.
//
// Ports:
//   clk        in  1  clock
//   reset      in  1  asynchronous, active-low reset
//   key_raw    in  1  raw asynchronous key level
//   key_event  out 1  one-cycle pulse when the accepted level rises
// -----------------------------------------------------------------------------
module key_edge #(
   parameter int unsigned DEBOUNCE = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_event
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             armed;
   logic [CNT_W-1:0] cnt;

   // After reset the key is not trusted until it has been seen stably low for
   // a full debounce period, so a key held through reset release never yields
   // an event. Once armed, the counter runs while the synchronized sample
   // differs from the accepted level and restarts whenever they agree; the
   // event is raised in the same cycle the accepted level goes high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         level     <= 1'b0;
         armed     <= 1'b0;
         cnt       <= '0;
         key_event <= 1'b0;
      end else begin
         sync1     <= key_raw;
         sync2     <= sync1;
         key_event <= 1'b0;
         if (!armed) begin
            if (sync2) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               armed <= 1'b1;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else if (sync2 != level) begin
            if (cnt == CNT_LAST) begin
               level     <= sync2;
               key_event <= sync2;
               cnt       <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/candy_vend_ctrl.sv
// -----------------------------------------------------------------------------
// candy_vend_ctrl
// Sequencing controller for the candy vending datapath: debounced key events,
// credit register and the IDLE / DISPENSE / CHANGE state machine.
//
// Ports:
//   clk          in  1  clock, rising edge
//   reset        in  1  asynchronous, active-low reset
//   key_in       in  6  raw keys: [5] coin100 [4] coin50 [3] coin10
//                       [2] buy [1] return [0] ignored
//   credit       out 8  current credit
//   candy        out 1  dispense actuator, high DISP_CYCLES cycles
//   change_beg   out 3  one-hot change strobe: [2]=100 [1]=50 [0]=10
//   change_obeg  out 1  high while change is being returned
//   reject       out 1  one-cycle pulse on a refused coin or buy
// -----------------------------------------------------------------------------
module candy_vend_ctrl #(
   parameter int unsigned PRICE       = 70,
   parameter int unsigned CREDIT_MAX  = 250,
   parameter int unsigned DEBOUNCE    = 16,
   parameter int unsigned DISP_CYCLES = 4,
   parameter int unsigned CHG_GAP     = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] key_in,
   output logic [7:0] credit,
   output logic       candy,
   output logic [2:0] change_beg,
   output logic       change_obeg,
   output logic       reject
);

   import candy_pkg::*;

   localparam logic [7:0] PRICE_C   = 8'(PRICE);
   localparam logic [8:0] CMAX_C    = 9'(CREDIT_MAX);
   localparam logic [7:0] DISP_LAST = 8'(DISP_CYCLES - 1);
   localparam logic [7:0] GAP_LAST  = 8'(CHG_GAP - 1);

   logic [5:1] key_ev;
   logic       unused_key0;
   logic [1:0] state;
   logic [7:0] seq_cnt;
   logic       coin_ev;
   logic [7:0] coin_val;
   logic       buy_ev;
   logic       ret_ev;
   logic [8:0] credit_sum;
   logic [2:0] chg_pick;

   assign unused_key0 = key_in[0];

   key_edge #(.DEBOUNCE(DEBOUNCE)) u_key_c100 (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[KEY_C100]),
      .key_event (key_ev[KEY_C100])
   );

   key_edge #(.DEBOUNCE(DEBOUNCE)) u_key_c50 (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[KEY_C50]),
      .key_event (key_ev[KEY_C50])
   );

   key_edge #(.DEBOUNCE(DEBOUNCE)) u_key_c10 (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[KEY_C10]),
      .key_event (key_ev[KEY_C10])
   );

   key_edge #(.DEBOUNCE(DEBOUNCE)) u_key_buy (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[KEY_BUY]),
      .key_event (key_ev[KEY_BUY])
   );

   key_edge #(.DEBOUNCE(DEBOUNCE)) u_key_ret (
      .clk       (clk),
      .reset     (reset),
      .key_raw   (key_in[KEY_RET]),
      .key_event (key_ev[KEY_RET])
   );

   // Only the highest-priority event of a cycle survives; anything lower in
   // the same cycle is dropped without a reject.
   always_comb begin
      coin_ev  = 1'b0;
      coin_val = 8'd0;
      buy_ev   = 1'b0;
      ret_ev   = 1'b0;
      if (key_ev[KEY_C100]) begin
         coin_ev  = 1'b1;
         coin_val = COIN_100;
      end else if (key_ev[KEY_C50]) begin
         coin_ev  = 1'b1;
         coin_val = COIN_50;
      end else if (key_ev[KEY_C10]) begin
         coin_ev  = 1'b1;
         coin_val = COIN_10;
      end else if (key_ev[KEY_BUY]) begin
         buy_ev = 1'b1;
      end else if (key_ev[KEY_RET]) begin
         ret_ev = 1'b1;
      end
   end

   // Nine-bit sum so an overflowing coin is caught before credit can wrap.
   assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
   assign chg_pick   = change_pick(credit);

   assign change_obeg = (state == ST_CHANGE);

   // Main sequencer. seq_cnt counts candy cycles in DISPENSE and the gap
   // between change strobes in CHANGE; entering CHANGE with seq_cnt at zero
   // makes the first strobe fire on the very next cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         credit     <= 8'd0;
         candy      <= 1'b0;
         change_beg <= 3'b000;
         reject     <= 1'b0;
         seq_cnt    <= 8'd0;
      end else begin
         reject     <= 1'b0;
         change_beg <= 3'b000;
         case (state)
            ST_IDLE: begin
               if (coin_ev) begin
                  if (credit_sum <= CMAX_C)
                     credit <= credit_sum[7:0];
                  else
                     reject <= 1'b1;
               end else if (buy_ev) begin
                  if (credit >= PRICE_C) begin
                     credit  <= credit - PRICE_C;
                     candy   <= 1'b1;
                     seq_cnt <= 8'd0;
                     state   <= ST_DISPENSE;
                  end else begin
                     reject <= 1'b1;
                  end
               end else if (ret_ev && credit != 8'd0) begin
                  seq_cnt <= 8'd0;
                  state   <= ST_CHANGE;
               end
            end
            ST_DISPENSE: begin
               if (coin_ev)
                  reject <= 1'b1;
               if (seq_cnt == DISP_LAST) begin
                  candy   <= 1'b0;
                  seq_cnt <= 8'd0;
                  state   <= (credit != 8'd0) ? ST_CHANGE : ST_IDLE;
               end else begin
                  seq_cnt <= seq_cnt + 8'd1;
               end
            end
            ST_CHANGE: begin
               if (coin_ev)
                  reject <= 1'b1;
               if (credit == 8'd0) begin
                  state <= ST_IDLE;
               end else if (seq_cnt == 8'd0) begin
                  change_beg <= chg_pick;
                  credit     <= credit - change_value(chg_pick);
                  seq_cnt    <= GAP_LAST;
               end else begin
                  seq_cnt <= seq_cnt - 8'd1;
               end
            end
            default: begin
               candy <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/candy_vend_ctrl.md
# candy_vend_ctrl

Sequencing controller for the candy vending datapath. Takes the raw 6-bit key bank, debounces and edge-detects it, keeps the customer's credit, and runs the dispense / change-return state machine. It drives the candy strobe, the change-coin strobes and the credit value shown on the display, and sits between the key inputs and the display/actuator logic inside `candy_top`.

## Interface
- `PRICE`, 70: candy price in credit units; must be a multiple of 10 and at most `CREDIT_MAX`.
- `CREDIT_MAX`, 250: upper bound on credit; must be a multiple of 10 and ≤ 255.
- `DEBOUNCE`, 16: cycles a synchronized key level must stay stable before it is accepted.
- `DISP_CYCLES`, 4: length of the `candy` pulse in cycles.
- `CHG_GAP`, 4: cycles between successive change-coin strobes.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `key_in` in 6: raw key levels. [5] coin 100, [4] coin 50, [3] coin 10, [2] buy, [1] return, [0] unused and ignored.
- `credit` out 8: current credit, unsigned binary.
- `candy` out 1: dispense actuator, high for `DISP_CYCLES` cycles.
- `change_beg` out 3: one-hot change-coin strobe, one cycle per coin. [2] = 100, [1] = 50, [0] = 10.
- `change_obeg` out 1: change return in progress (high throughout CHANGE).
- `reject` out 1: one-cycle pulse when a coin or buy request is refused.

## Operation
- **Key front end, per bit 5..1:**
  - 2-flop synchronizer, then a stability counter.
  - The accepted level updates after `DEBOUNCE` consecutive equal samples.
  - A 0→1 transition of the accepted level produces a one-cycle event.
  - Holding a key produces exactly one event.
- **Same-cycle events:** priority is coin100 > coin50 > coin10 > buy > return. Lower-priority events in that cycle are dropped silently.
- **FSM states:** IDLE, DISPENSE, CHANGE.
- **IDLE:**
  - Coin event: if `credit + value ≤ CREDIT_MAX`, add the value to `credit`. Otherwise leave credit unchanged and pulse `reject`.
  - Buy with `credit ≥ PRICE`: subtract `PRICE` from credit and go to DISPENSE.
  - Buy with `credit < PRICE`: pulse `reject`, stay in IDLE.
  - Return with `credit > 0`: go to CHANGE. Return with credit 0 is ignored.
- **DISPENSE:**
  - `candy` is high for exactly `DISP_CYCLES` cycles, starting the cycle after the buy event is registered.
  - On exit, go to CHANGE if credit > 0, else IDLE.
- **CHANGE:**
  - Every `CHG_GAP` cycles, strobe the largest coin ≤ credit (100, then 50, then 10) and subtract its value from credit in the same cycle.
  - When credit reaches 0, go to IDLE on the next cycle.
  - `change_obeg` is high for the whole state.
- **Events outside IDLE:** coin events in DISPENSE or CHANGE are refused (`reject` pulse, no credit change). Buy and return events there are ignored.
- **Arithmetic:** additions are done 9 bits wide before the `CREDIT_MAX` compare, so credit never wraps.

## Timing
- **Reset values:**
  - `credit` = 0, `candy` = 0, `change_beg` = 0, `change_obeg` = 0, `reject` = 0.
  - FSM in IDLE; synchronizers, debounce counters and accepted levels cleared.
- **Key latency:** a key level change propagates to an event in 2 + `DEBOUNCE` cycles. `credit` updates 1 cycle after the event.
- **Buy:** `candy` rises 1 cycle after the buy event; the credit decrement is visible in that same cycle.
- **Change:**
  - First `change_beg` strobe comes 1 cycle after CHANGE is entered; later strobes come every `CHG_GAP` cycles.
  - `change_obeg` falls the cycle after the last strobe.
- **`reject`:** asserted the cycle after the offending event, for exactly 1 cycle.
- **Reset mid-operation:** all state is abandoned immediately. Credit is lost, and any `candy` or change strobe in progress is cut off asynchronously.
- **Key held through reset release:** it must be seen low and then high again, after debounce, to generate an event.

## Structure
- **Shared package `candy_pkg`:**
  - FSM state encoding.
  - Coin value constants (10/50/100).
  - Key bit index constants for `key_in`.
- **Sub-module `key_edge`:** one instance per key bit. It holds the synchronizer, the `DEBOUNCE` counter and the rising-edge pulse.
- **Top FSM, credit register and gap/dispense counter** live in `candy_vend_ctrl`.

## Test plan
1. **Basic buy:** coin100 held 2000 cycles, then buy held 2000 cycles.
   - credit shows 100.
   - `candy` high 4 cycles; credit becomes 30.
   - Three `change_beg` = 001 strobes 4 cycles apart; credit 0; `change_obeg` high from entering CHANGE until the cycle after the third strobe.
2. **Insufficient credit:** coin50 then buy.
   - `reject` pulses once, no `candy`, credit stays 50.
   - Return then gives one 050 strobe (`change_beg` = 010) and credit 0.
3. **Overflow:** coin100 ×2, coin50, then coin10.
   - Credit 250 after the first three coins.
   - coin10 → `reject`, credit stays 250.
   - Return → strobes 100, 100, 50.
4. **Simultaneous keys:** coin100 and coin10 rising in the same cycle → credit +100 only, no `reject`.
5. **Coin during dispense/change:** coin10 debounced while `candy` or `change_obeg` is high → `reject`, credit sequence unaffected.
6. **Bounce and reset:**
   - A key toggling faster than 16 cycles produces no event.
   - Reset asserted during CHANGE with credit 30 → all outputs 0 at once, credit 0 after release, no further strobes.
